// File: rtl/encoder_8to3_reg.sv
// Registered 8-to-3 priority encoder with zero and multi-hot flags.
// Winning bit is selected by PRIO_MSB; all outputs have one cycle latency.
module encoder_8to3_reg #(
  parameter bit PRIO_MSB = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] A,
  output logic [2:0] D,
  output logic       valid,
  output logic       multi
);

  logic [2:0] d_q, d_d;
  logic       valid_q, valid_d;
  logic       multi_q, multi_d;

  always_comb begin
    d_d = 3'd0;
    if (PRIO_MSB) begin
      for (int i = 0; i < 8; i++) begin
        if (A[i]) d_d = 3'(i);
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (A[i]) d_d = 3'(i);
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign valid_d = |A;
  assign multi_d = |(A & (A - 8'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q     <= 3'd0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
    end else if (en) begin
      d_q     <= d_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
    end
  end

  assign D     = d_q;
  assign valid = valid_q;
  assign multi = multi_q;

endmodule

// File: tb/tb_encoder_8to3_reg.sv
// Self-checking bench for encoder_8to3_reg, both priority settings.
// Reference model works from bit counts and an ordered bit search.
module tb_encoder_8to3_reg;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] A;
  logic [2:0] d_h, d_l;
  logic       v_h, v_l, m_h, m_l;

  int checks;
  int failures;

  logic [4:0] exp_h, exp_l;

  encoder_8to3_reg #(.PRIO_MSB(1'b1)) u_hi (
    .clk(clk), .rst_n(rst_n), .en(en), .A(A),
    .D(d_h), .valid(v_h), .multi(m_h)
  );

  encoder_8to3_reg #(.PRIO_MSB(1'b0)) u_lo (
    .clk(clk), .rst_n(rst_n), .en(en), .A(A),
    .D(d_l), .valid(v_l), .multi(m_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] ref_enc(input logic [7:0] a,
                                         input bit msb);
    int n;
    int idx;
    n   = $countones(a);
    idx = 0;
    if (n > 0) begin
      if (msb) begin
        idx = 7;
        while (!a[idx]) idx--;
      end else begin
        idx = 0;
        while (!a[idx]) idx++;
      end
    end
    return {3'(idx), n >= 1, n >= 2};
  endfunction

  task automatic chk(input string tag, input logic [4:0] got,
                     input logic [4:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got={D,v,m}=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic chk_both(input string tag);
    chk({tag, "/msb"}, {d_h, v_h, m_h}, exp_h);
    chk({tag, "/lsb"}, {d_l, v_l, m_l}, exp_l);
  endtask

  task automatic step(input logic [7:0] a, input logic e,
                      input string tag);
    @(negedge clk);
    A  = a;
    en = e;
    @(posedge clk);
    #1;
    if (e) begin
      exp_h = ref_enc(a, 1'b1);
      exp_l = ref_enc(a, 1'b0);
    end
    chk_both(tag);
  endtask

  task automatic step_lit(input logic [7:0] a, input logic [4:0] eh,
                          input logic [4:0] el, input string tag);
    step(a, 1'b1, tag);
    chk({tag, "/lit_msb"}, {d_h, v_h, m_h}, eh);
    chk({tag, "/lit_lsb"}, {d_l, v_l, m_l}, el);
  endtask

  initial begin
    logic [7:0] oh;
    checks   = 0;
    failures = 0;
    exp_h    = 5'd0;
    exp_l    = 5'd0;
    rst_n    = 1'b0;
    en       = 1'b1;
    A        = 8'hFF;

    repeat (3) @(posedge clk);
    #1;
    chk_both("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_both("reset_release");

    for (int i = 0; i < 8; i++) begin
      oh = 8'd1 << i;
      step_lit(oh, {3'(i), 2'b10}, {3'(i), 2'b10}, "onehot");
    end
    step_lit(8'h00, 5'b00000, 5'b00000, "zero");

    step_lit(8'hFF, {3'd7, 2'b11}, {3'd0, 2'b11}, "prio_ff");
    step_lit(8'h18, {3'd4, 2'b11}, {3'd3, 2'b11}, "prio_18");
    step_lit(8'h81, {3'd7, 2'b11}, {3'd0, 2'b11}, "prio_81");
    step_lit(8'h52, {3'd6, 2'b11}, {3'd1, 2'b11}, "prio_52");

    step_lit(8'h20, {3'd5, 2'b10}, {3'd5, 2'b10}, "hold_cap");
    step(8'h01, 1'b0, "hold1");
    step(8'h00, 1'b0, "hold2");
    step(8'h01, 1'b0, "hold3");
    chk("hold_lit", {d_h, v_h, m_h}, {3'd5, 2'b10});
    step_lit(8'h01, {3'd0, 2'b10}, {3'd0, 2'b10}, "hold_resume");

    step_lit(8'hC3, {3'd7, 2'b11}, {3'd0, 2'b11}, "pre_rst");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    exp_h = 5'd0;
    exp_l = 5'd0;
    chk_both("async_rst");
    @(posedge clk);
    #1;
    chk_both("rst_en_edge");
    @(negedge clk);
    rst_n = 1'b1;
    A     = 8'h0C;
    en    = 1'b0;
    #1;
    chk_both("rst_rel_mid");
    step(8'h0C, 1'b1, "post_rst");

    for (int i = 0; i < 256; i++) begin
      step(8'(i), 1'b1, "sweep");
    end

    for (int i = 0; i < 200; i++) begin
      step(8'($urandom), 1'($urandom_range(0, 3) != 0), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
